// File: rtl/fdiv_seq.sv
// Sequential IEEE-754 single-precision divider: restoring division, one quotient
// bit per cycle, denormals flushed to zero, rounding per rm.
module fdiv_seq #(
    parameter int unsigned ITER = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    input  logic [2:0]  rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_num,
    output logic [4:0]  flags
);

    localparam int unsigned CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

    state_t      state;
    logic        sign_q;
    logic [7:0]  ea_q, eb_q;
    logic [2:0]  rm_q;
    logic [23:0] mb_q;
    logic [24:0] rem_q;
    logic [25:0] quo_q;
    logic [CW-1:0] cnt_q;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Special-operand classification straight from the input ports
    logic        s_res, nan1, nan2, snan1, snan2, inf1, inf2, z1, z2;
    logic        spec_hit;
    logic [31:0] spec_num;
    logic [4:0]  spec_flags;

    always_comb begin
        s_res = num1[31] ^ num2[31];
        nan1  = (num1[30:23] == 8'hFF) && (num1[22:0] != '0);
        nan2  = (num2[30:23] == 8'hFF) && (num2[22:0] != '0);
        snan1 = nan1 && !num1[22];
        snan2 = nan2 && !num2[22];
        inf1  = (num1[30:23] == 8'hFF) && (num1[22:0] == '0);
        inf2  = (num2[30:23] == 8'hFF) && (num2[22:0] == '0);
        z1    = (num1[30:23] == 8'h00);
        z2    = (num2[30:23] == 8'h00);
        spec_hit   = 1'b1;
        spec_num   = '0;
        spec_flags = '0;
        if (nan1 || nan2 || (z1 && z2) || (inf1 && inf2)) begin
            spec_num   = 32'h7FC0_0000;
            spec_flags = {(snan1 || snan2 || (z1 && z2) || (inf1 && inf2)), 4'b0000};
        end else if (inf1) begin
            spec_num = {s_res, 8'hFF, 23'd0};
        end else if (z2) begin
            spec_num   = {s_res, 8'hFF, 23'd0};
            spec_flags = 5'b01000;
        end else if (z1 || inf2) begin
            spec_num = {s_res, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // One restoring step; a non-negative difference is always below mb, so 24 bits hold it
    logic        ge;
    logic [23:0] diff;

    always_comb begin
        ge   = (rem_q >= {1'b0, mb_q});
        diff = ge ? 24'(rem_q - {1'b0, mb_q}) : rem_q[23:0];
    end

    // Normalise, round and range-check the finished quotient
    logic [23:0]       mant;
    logic              guard, sticky, inc;
    logic signed [9:0] exp_n, exp_r;
    logic [24:0]       mr;
    logic [22:0]       frac;
    logic [31:0]       rnd_num;
    logic [4:0]        rnd_flags;

    always_comb begin
        if (quo_q[25]) begin
            mant   = quo_q[25:2];
            guard  = quo_q[1];
            sticky = quo_q[0] | (rem_q != '0);
            exp_n  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
        end else begin
            mant   = quo_q[24:1];
            guard  = quo_q[0];
            sticky = (rem_q != '0);
            exp_n  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd126;
        end
        case (rm_q)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sign_q & (guard | sticky);
            3'b011:  inc = ~sign_q & (guard | sticky);
            3'b100:  inc = guard;
            default: inc = guard & (sticky | mant[0]);
        endcase
        mr    = {1'b0, mant} + {24'd0, inc};
        frac  = mr[24] ? mr[23:1] : mr[22:0];
        exp_r = exp_n + (mr[24] ? 10'sd1 : 10'sd0);
        if (exp_r >= 10'sd255) begin
            rnd_flags = 5'b00101;
            case (rm_q)
                3'b001:  rnd_num = {sign_q, 31'h7F7F_FFFF};
                3'b010:  rnd_num = sign_q ? {sign_q, 31'h7F80_0000} : {sign_q, 31'h7F7F_FFFF};
                3'b011:  rnd_num = sign_q ? {sign_q, 31'h7F7F_FFFF} : {sign_q, 31'h7F80_0000};
                default: rnd_num = {sign_q, 31'h7F80_0000};
            endcase
        end else if (exp_r <= 10'sd0) begin
            rnd_num   = {sign_q, 31'd0};
            rnd_flags = 5'b00011;
        end else begin
            rnd_num   = {sign_q, exp_r[7:0], frac};
            rnd_flags = {4'b0000, guard | sticky};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            out_num <= '0;
            flags   <= '0;
            sign_q  <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            rm_q    <= '0;
            mb_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= s_res;
                        ea_q   <= num1[30:23];
                        eb_q   <= num2[30:23];
                        rm_q   <= rm;
                        mb_q   <= {1'b1, num2[22:0]};
                        rem_q  <= {2'b01, num1[22:0]};
                        quo_q  <= '0;
                        cnt_q  <= '0;
                        if (spec_hit) begin
                            out_num <= spec_num;
                            flags   <= spec_flags;
                            state   <= DONE;
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    quo_q <= {quo_q[24:0], ge};
                    rem_q <= {diff, 1'b0};
                    if (cnt_q == CW'(ITER - 1)) begin
                        state <= ROUND;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ROUND: begin
                    out_num <= rnd_num;
                    flags   <= rnd_flags;
                    state   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed testbench for fdiv_seq with hand-computed expected quotients and flags.
module tb_fdiv_seq;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] num1, num2, out_num;
    logic [2:0]  rm;
    logic [4:0]  flags;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    fdiv_seq #(.ITER(26)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .num1(num1), .num2(num2), .rm(rm), .out_valid(out_valid),
        .out_ready(out_ready), .out_num(out_num), .flags(flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Latency counts edges after the acceptance edge until out_valid is seen high
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] r, input logic [31:0] en, input logic [4:0] ef,
                          input int elat);
        int n;
        @(negedge clk);
        num1 = a; num2 = b; rm = r; in_valid = 1'b1;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(elat));
        check({tag, " out_num"}, out_num, en);
        check({tag, " flags"}, 32'(flags), 32'(ef));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " drop"}, 32'(out_valid), 32'd0);
        check({tag, " ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        num1 = '0; num2 = '0; rm = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_num", out_num, 32'd0);
        check("rst flags", 32'(flags), 32'd0);
        rst = 1'b0;

        run_op("6/2 rne",   32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 5'b00000, 27);
        run_op("1/3 rne",   32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 5'b00001, 27);
        run_op("1/3 rtz",   32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 5'b00001, 27);
        run_op("1/3 rup",   32'h3F800000, 32'h40400000, 3'b011, 32'h3EAAAAAB, 5'b00001, 27);
        run_op("1/3 rm101", 32'h3F800000, 32'h40400000, 3'b101, 32'h3EAAAAAB, 5'b00001, 27);
        run_op("-1/3 rdn",  32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAB, 5'b00001, 27);
        run_op("-1/3 rup",  32'hBF800000, 32'h40400000, 3'b011, 32'hBEAAAAAA, 5'b00001, 27);
        run_op("-6/2",      32'hC0C00000, 32'h40000000, 3'b000, 32'hC0400000, 5'b00000, 27);
        run_op("1/1+ulp",   32'h3F800000, 32'h3F800001, 3'b000, 32'h3F7FFFFE, 5'b00001, 27);
        run_op("1/1+ulp up",32'h3F800000, 32'h3F800001, 3'b011, 32'h3F7FFFFF, 5'b00001, 27);
        run_op("ovf rne",   32'h7F7FFFFF, 32'h3F000000, 3'b000, 32'h7F800000, 5'b00101, 27);
        run_op("ovf rtz",   32'h7F7FFFFF, 32'h3F000000, 3'b001, 32'h7F7FFFFF, 5'b00101, 27);
        run_op("ovf rdn+",  32'h7F7FFFFF, 32'h3F000000, 3'b010, 32'h7F7FFFFF, 5'b00101, 27);
        run_op("ovf rdn-",  32'hFF7FFFFF, 32'h3F000000, 3'b010, 32'hFF800000, 5'b00101, 27);
        run_op("flush",     32'h00800000, 32'h7F000000, 3'b000, 32'h00000000, 5'b00011, 27);
        run_op("1/0",       32'h3F800000, 32'h00000000, 3'b000, 32'h7F800000, 5'b01000, 0);
        run_op("1/-0",      32'h3F800000, 32'h80000000, 3'b000, 32'hFF800000, 5'b01000, 0);
        run_op("0/0",       32'h00000000, 32'h00000000, 3'b000, 32'h7FC00000, 5'b10000, 0);
        run_op("inf/inf",   32'h7F800000, 32'h7F800000, 3'b000, 32'h7FC00000, 5'b10000, 0);
        run_op("snan",      32'h7F800001, 32'h3F800000, 3'b000, 32'h7FC00000, 5'b10000, 0);
        run_op("qnan",      32'h7FC00000, 32'h3F800000, 3'b000, 32'h7FC00000, 5'b00000, 0);
        run_op("inf/2",     32'h7F800000, 32'h40000000, 3'b000, 32'h7F800000, 5'b00000, 0);
        run_op("2/inf",     32'h40000000, 32'h7F800000, 3'b000, 32'h00000000, 5'b00000, 0);
        run_op("-denorm/1", 32'h80000001, 32'h3F800000, 3'b000, 32'h80000000, 5'b00000, 0);

        // Back-pressure: result held while new operands are offered and refused
        @(negedge clk);
        num1 = 32'h3F800000; num2 = 32'h40400000; rm = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp latency", 32'(n), 32'd27);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            num1 = 32'h40C00000; num2 = 32'h40000000; in_valid = 1'b1; out_ready = 1'b0;
            @(posedge clk); #1;
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp out_num", out_num, 32'h3EAAAAAB);
            check("bp flags", 32'(flags), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready", 32'(in_ready), 32'd1);

        // Reset in the tenth DIV cycle discards the computation
        @(negedge clk);
        num1 = 32'h3F800000; num2 = 32'h40400000; rm = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst out_num", out_num, 32'd0);
        check("midrst flags", 32'(flags), 32'd0);
        repeat (30) @(posedge clk);
        #1;
        check("midrst no output", 32'(out_valid), 32'd0);
        run_op("post-rst 6/2", 32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 5'b00000, 27);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
